// File: rtl/fbuff_writer.sv
// Frame-buffer write master: packs TILE_PER_ROW tile colours into one row and
// writes rows to consecutive addresses 0..FBUFF_DEPTH-1, one frame per start_i.
module fbuff_writer #(
   parameter int PXL_WIDTH        = 12,
   parameter int TILE_PER_ROW     = 5,
   parameter int FBUFF_DEPTH      = 3840,
   parameter int FBUFF_ADDR_WIDTH = 12,
   parameter int FBUFF_DATA_WIDTH = TILE_PER_ROW * PXL_WIDTH
) (
   input  logic                        clk_i,
   input  logic                        rstn_i,
   input  logic                        start_i,
   input  logic                        abort_i,
   input  logic [PXL_WIDTH-1:0]        tile_data_i,
   input  logic                        tile_valid_i,
   output logic                        tile_ready_o,
   output logic [FBUFF_ADDR_WIDTH-1:0] fbuff_addr_o,
   output logic [FBUFF_DATA_WIDTH-1:0] fbuff_data_o,
   output logic                        fbuff_en_o,
   output logic                        fbuff_wen_o,
   output logic                        busy_o,
   output logic                        frame_done_o
);

   localparam int IDX_W = (TILE_PER_ROW > 1) ? $clog2(TILE_PER_ROW) : 1;
   localparam logic [IDX_W-1:0]            LAST_IDX = IDX_W'(TILE_PER_ROW - 1);
   localparam logic [IDX_W-1:0]            IDX_ONE  = IDX_W'(1);
   localparam logic [FBUFF_ADDR_WIDTH-1:0] LAST_ROW = FBUFF_ADDR_WIDTH'(FBUFF_DEPTH - 1);
   localparam logic [FBUFF_ADDR_WIDTH-1:0] ROW_ONE  = FBUFF_ADDR_WIDTH'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FILL  = 2'd1,
      S_WRITE = 2'd2
   } state_t;

   state_t                        state_q, state_d;
   logic [IDX_W-1:0]              tile_idx_q, tile_idx_d;
   logic [FBUFF_ADDR_WIDTH-1:0]   row_addr_q, row_addr_d;
   logic [FBUFF_DATA_WIDTH-1:0]   pack_q, pack_d;
   logic [FBUFF_ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [FBUFF_DATA_WIDTH-1:0]   data_q, data_d;
   logic                          strobe_q, strobe_d;
   logic                          busy_q, busy_d;
   logic                          done_q, done_d;
   logic                          xfer;

   // Handshake: a tile moves on any cycle where tile_valid_i and tile_ready_o
   // are both high at the rising edge; ready depends only on the FSM state.
   assign tile_ready_o = (state_q == S_FILL);
   assign xfer         = tile_ready_o & tile_valid_i;

   // State register
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; abort wins over start and over a pending write
   always_comb begin
      state_d = state_q;
      if (abort_i) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:  if (start_i) state_d = S_FILL;
            S_FILL:  if (xfer && (tile_idx_q == LAST_IDX)) state_d = S_WRITE;
            S_WRITE: state_d = (row_addr_q == LAST_ROW) ? S_IDLE : S_FILL;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Datapath and registered-output next values
   always_comb begin
      tile_idx_d = tile_idx_q;
      row_addr_d = row_addr_q;
      pack_d     = pack_q;
      addr_d     = addr_q;
      data_d     = data_q;
      strobe_d   = 1'b0;
      done_d     = 1'b0;
      busy_d     = (state_d != S_IDLE);
      if (abort_i) begin
         tile_idx_d = '0;
         row_addr_d = '0;
      end else begin
         case (state_q)
            S_FILL: begin
               if (xfer) begin
                  pack_d[tile_idx_q*PXL_WIDTH +: PXL_WIDTH] = tile_data_i;
                  if (tile_idx_q == LAST_IDX) begin
                     tile_idx_d = '0;
                     strobe_d   = 1'b1;
                     addr_d     = row_addr_q;
                     data_d     = pack_d;
                  end else begin
                     tile_idx_d = tile_idx_q + IDX_ONE;
                  end
               end
            end
            S_WRITE: begin
               if (row_addr_q == LAST_ROW) begin
                  row_addr_d = '0;
                  done_d     = 1'b1;
               end else begin
                  row_addr_d = row_addr_q + ROW_ONE;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         tile_idx_q <= '0;
         row_addr_q <= '0;
         pack_q     <= '0;
         addr_q     <= '0;
         data_q     <= '0;
         strobe_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         tile_idx_q <= tile_idx_d;
         row_addr_q <= row_addr_d;
         pack_q     <= pack_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         strobe_q   <= strobe_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   // The strobe was launched a cycle early, so an abort arriving during the
   // WRITE cycle must still be able to cancel it at the memory port.
   assign fbuff_en_o   = strobe_q & ~abort_i;
   assign fbuff_wen_o  = strobe_q & ~abort_i;
   assign fbuff_addr_o = addr_q;
   assign fbuff_data_o = data_q;
   assign busy_o       = busy_q;
   assign frame_done_o = done_q;

endmodule

// File: tb/tb_fbuff_writer.sv
// Directed bench for fbuff_writer: reset, single row, full frame, gapped
// stream, mid-row abort and start/abort collisions against a write log.
module tb_fbuff_writer;

   localparam int PW    = 12;
   localparam int TPR   = 5;
   localparam int DEPTH = 3840;
   localparam int AW    = 12;
   localparam int DW    = 60;
   localparam int TILES = DEPTH * TPR;

   logic          clk = 1'b0;
   logic          rstn_i = 1'b0;
   logic          start_i = 1'b0;
   logic          abort_i = 1'b0;
   logic [PW-1:0] tile_data_i = '0;
   logic          tile_valid_i = 1'b0;
   logic          tile_ready_o;
   logic [AW-1:0] fbuff_addr_o;
   logic [DW-1:0] fbuff_data_o;
   logic          fbuff_en_o;
   logic          fbuff_wen_o;
   logic          busy_o;
   logic          frame_done_o;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   bit stuck = 1'b0;
   logic [AW-1:0] wr_addr_q[$];
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] wr_data_q[$];
   logic [DW-1:0] mem_ref[DEPTH];

   fbuff_writer dut (
      .clk_i        (clk),
      .rstn_i       (rstn_i),
      .start_i      (start_i),
      .abort_i      (abort_i),
      .tile_data_i  (tile_data_i),
      .tile_valid_i (tile_valid_i),
      .tile_ready_o (tile_ready_o),
      .fbuff_addr_o (fbuff_addr_o),
      .fbuff_data_o (fbuff_data_o),
      .fbuff_en_o   (fbuff_en_o),
      .fbuff_wen_o  (fbuff_wen_o),
      .busy_o       (busy_o),
      .frame_done_o (frame_done_o)
   );

   // clock / reset block
   always #5 clk = ~clk;

   // write monitor: inputs change 1 ns after posedge, so negedge is quiet
   always @(negedge clk) begin
      if (rstn_i) begin
         if (fbuff_en_o && fbuff_wen_o) begin
            wr_addr_q.push_back(fbuff_addr_o);
            wr_data_q.push_back(fbuff_data_o);
         end
         if (frame_done_o) done_cnt++;
      end
   end

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [PW-1:0] tile_val(input int n);
      logic [31:0] h;
      h = 32'(n) * 32'd40503 + 32'd17;
      return h[15:4];
   endfunction

   function automatic logic [DW-1:0] row_val(input int r);
      logic [DW-1:0] v;
      v = '0;
      for (int k = 0; k < TPR; k++) v[k*PW +: PW] = tile_val(r*TPR + k);
      return v;
   endfunction

   // number of logged writes that differ from the expected frame sequence
   function automatic int bad_rows(input bit use_ref);
      int bad;
      bad = 0;
      for (int i = 0; i < wr_addr_q.size(); i++) begin
         if (wr_addr_q[i] !== AW'(i) || wr_data_q[i] !== exp_q[i]) bad++;
         else if (use_ref && wr_data_q[i] !== mem_ref[i]) bad++;
      end
      return bad;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      wr_addr_q.delete();
      wr_data_q.delete();
      exp_q.delete();
      done_cnt = 0;
   endtask

   task automatic pulse_start();
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
   endtask

   task automatic pulse_abort();
      abort_i = 1'b1;
      tick();
      abort_i = 1'b0;
   endtask

   // driver: holds one tile until it is taken; valid left high on return
   task automatic send_tile(input logic [PW-1:0] d, input bit gappy);
      int  guard;
      bit  acc;
      if (stuck) return;
      guard = 0;
      acc = 1'b0;
      tile_data_i = d;
      while (!acc && guard < 200) begin
         tile_valid_i = gappy ? 1'($urandom_range(0, 1)) : 1'b1;
         acc = tile_valid_i && tile_ready_o;
         tick();
         guard++;
      end
      if (!acc) begin
         checks++; errors++; stuck = 1'b1;
         $display("FAIL tile_accept: tile %h not taken within %0d cycles", d, guard);
      end
   endtask

   task automatic test_reset();
      rstn_i = 1'b0;
      tile_valid_i = 1'b1;
      tile_data_i = 12'hABC;
      repeat (3) tick();
      checks++; if (tile_ready_o !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b exp 0", tile_ready_o); end
      checks++; if (fbuff_addr_o !== '0) begin errors++; $display("FAIL rst_addr: got %h exp 0", fbuff_addr_o); end
      checks++; if (fbuff_data_o !== '0) begin errors++; $display("FAIL rst_data: got %h exp 0", fbuff_data_o); end
      checks++; if ({fbuff_en_o, fbuff_wen_o, busy_o, frame_done_o} !== 4'b0) begin
         errors++; $display("FAIL rst_ctrl: got en/wen/busy/done %b exp 0000", {fbuff_en_o, fbuff_wen_o, busy_o, frame_done_o});
      end
      tile_valid_i = 1'b0;
      rstn_i = 1'b1;
      repeat (2) tick();
      checks++; if (busy_o !== 1'b0 || wr_addr_q.size() != 0) begin
         errors++; $display("FAIL rst_idle: busy %b writes %0d exp 0/0", busy_o, wr_addr_q.size());
      end
   endtask

   task automatic test_single_row();
      clear_log();
      pulse_start();
      checks++; if (busy_o !== 1'b1 || tile_ready_o !== 1'b1) begin
         errors++; $display("FAIL row_fill: busy %b ready %b exp 1/1", busy_o, tile_ready_o);
      end
      send_tile(12'h111, 0); send_tile(12'h222, 0); send_tile(12'h333, 0);
      send_tile(12'h444, 0); send_tile(12'h555, 0);
      checks++; if (tile_ready_o !== 1'b0 || fbuff_en_o !== 1'b1 || fbuff_wen_o !== 1'b1) begin
         errors++; $display("FAIL row_strobe: ready %b en %b wen %b exp 0/1/1", tile_ready_o, fbuff_en_o, fbuff_wen_o);
      end
      checks++; if (fbuff_addr_o !== 12'd0 || fbuff_data_o !== 60'h555444333222111) begin
         errors++; $display("FAIL row_word: addr %h data %h exp 0/555444333222111", fbuff_addr_o, fbuff_data_o);
      end
      tile_valid_i = 1'b0;
      tick();
      checks++; if (tile_ready_o !== 1'b1 || fbuff_en_o !== 1'b0 || fbuff_data_o !== 60'h555444333222111) begin
         errors++; $display("FAIL row_after: ready %b en %b data %h exp 1/0/held", tile_ready_o, fbuff_en_o, fbuff_data_o);
      end
      checks++; if (wr_addr_q.size() != 1) begin errors++; $display("FAIL row_count: got %0d writes exp 1", wr_addr_q.size()); end
      pulse_abort();
   endtask

   task automatic test_full_frame(input bit gappy);
      int bad;
      clear_log();
      for (int r = 0; r < DEPTH; r++) exp_q.push_back(row_val(r));
      pulse_start();
      for (int i = 0; i < TILES; i++) begin
         if (!gappy && i == 500) start_i = 1'b1;
         send_tile(tile_val(i), gappy);
         start_i = 1'b0;
      end
      checks++; if (fbuff_en_o !== 1'b1 || fbuff_addr_o !== AW'(DEPTH-1)) begin
         errors++; $display("FAIL frame_last_strobe: en %b addr %0d exp 1/%0d", fbuff_en_o, fbuff_addr_o, DEPTH-1);
      end
      tile_valid_i = 1'b0;
      repeat (4) tick();
      checks++; if (wr_addr_q.size() != DEPTH) begin errors++; $display("FAIL frame_count: got %0d writes exp %0d", wr_addr_q.size(), DEPTH); end
      bad = bad_rows(gappy);
      checks++; if (bad != 0) begin errors++; $display("FAIL frame_rows: got %0d wrong rows exp 0", bad); end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL frame_done: got %0d pulse cycles exp 1", done_cnt); end
      checks++; if (busy_o !== 1'b0 || tile_ready_o !== 1'b0) begin
         errors++; $display("FAIL frame_idle: busy %b ready %b exp 0/0", busy_o, tile_ready_o);
      end
      if (!gappy) for (int i = 0; i < wr_data_q.size() && i < DEPTH; i++) mem_ref[i] = wr_data_q[i];
   endtask

   task automatic test_abort_mid_row();
      clear_log();
      pulse_start();
      for (int i = 0; i < 7*TPR + 3; i++) send_tile(tile_val(i), 0);
      tile_valid_i = 1'b0;
      tick();
      pulse_abort();
      checks++; if (busy_o !== 1'b0 || tile_ready_o !== 1'b0) begin
         errors++; $display("FAIL abort_idle: busy %b ready %b exp 0/0", busy_o, tile_ready_o);
      end
      repeat (3) tick();
      checks++; if (wr_addr_q.size() != 7 || done_cnt != 0) begin
         errors++; $display("FAIL abort_nowrite: writes %0d done %0d exp 7/0", wr_addr_q.size(), done_cnt);
      end
      pulse_start();
      send_tile(12'hA01, 0); send_tile(12'hA02, 0); send_tile(12'hA03, 0);
      send_tile(12'hA04, 0); send_tile(12'hA05, 0);
      tile_valid_i = 1'b0;
      tick();
      checks++; if (wr_addr_q.size() != 8 || wr_addr_q[$] !== 12'd0 || wr_data_q[$] !== 60'hA05A04A03A02A01) begin
         errors++; $display("FAIL abort_restart: writes %0d addr %h data %h exp 8/0/A05A04A03A02A01",
                            wr_addr_q.size(), wr_addr_q[$], wr_data_q[$]);
      end
      pulse_abort();
   endtask

   task automatic test_collisions();
      clear_log();
      pulse_start();
      send_tile(12'hB01, 0); send_tile(12'hB02, 0);
      start_i = 1'b1;
      send_tile(12'hB03, 0);
      start_i = 1'b0;
      send_tile(12'hB04, 0); send_tile(12'hB05, 0);
      tile_valid_i = 1'b0;
      tick();
      checks++; if (wr_addr_q.size() != 1 || wr_addr_q[$] !== 12'd0 || wr_data_q[$] !== 60'hB05B04B03B02B01) begin
         errors++; $display("FAIL busy_start: writes %0d addr %h data %h exp 1/0/B05B04B03B02B01",
                            wr_addr_q.size(), wr_addr_q[$], wr_data_q[$]);
      end
      abort_i = 1'b1; start_i = 1'b1;
      tick();
      abort_i = 1'b0; start_i = 1'b0;
      tick();
      checks++; if (busy_o !== 1'b0 || tile_ready_o !== 1'b0) begin
         errors++; $display("FAIL abort_start: busy %b ready %b exp 0/0", busy_o, tile_ready_o);
      end
      // abort during the WRITE of the final row
      clear_log();
      pulse_start();
      for (int i = 0; i < TILES; i++) send_tile(tile_val(i), 0);
      abort_i = 1'b1;
      #1;
      checks++; if (fbuff_en_o !== 1'b0 || fbuff_wen_o !== 1'b0) begin
         errors++; $display("FAIL abort_write_mask: en %b wen %b exp 0/0", fbuff_en_o, fbuff_wen_o);
      end
      tick();
      abort_i = 1'b0;
      tile_valid_i = 1'b0;
      repeat (4) tick();
      checks++; if (wr_addr_q.size() != DEPTH-1 || wr_addr_q[$] !== AW'(DEPTH-2) || done_cnt != 0) begin
         errors++; $display("FAIL abort_last_row: writes %0d last %0d done %0d exp %0d/%0d/0",
                            wr_addr_q.size(), wr_addr_q[$], done_cnt, DEPTH-1, DEPTH-2);
      end
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL abort_last_busy: got %b exp 0", busy_o); end
      pulse_start();
      send_tile(12'hC01, 0); send_tile(12'hC02, 0); send_tile(12'hC03, 0);
      send_tile(12'hC04, 0); send_tile(12'hC05, 0);
      tile_valid_i = 1'b0;
      tick();
      checks++; if (wr_addr_q[$] !== 12'd0 || wr_data_q[$] !== 60'hC05C04C03C02C01) begin
         errors++; $display("FAIL abort_last_restart: addr %h data %h exp 0/C05C04C03C02C01", wr_addr_q[$], wr_data_q[$]);
      end
      pulse_abort();
   endtask

   initial begin
      test_reset();
      test_single_row();
      test_full_frame(1'b0);
      test_full_frame(1'b1);
      test_abort_mid_row();
      test_collisions();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
